uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter that consumes the one-cycle `baud_tick` strobe from the baud generator. Both blocks run on `clk_3125` (3.125 MHz; 115200 baud gives one tick per 27 clocks).
- Accepts a byte over a valid/ready handshake and serialises it LSB-first on `tx`: start bit, DATA_BITS data bits, STOP_BITS stop bits.
- Sits between the security wrapper's output path and the serial pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk_3125  input  1  system clock, 3.125 MHz.
- reset  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-cycle bit-period strobe from the baud generator.
- tx_data  input  DATA_BITS  byte to send; sampled on handshake.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idle/mark = 1.
- tx_busy  output  1  a frame is pending or in progress.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (async, reset=0): state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, shift register=0, bit counter=0. Reset mid-frame aborts the frame and tx returns to 1 immediately; no tx_done is produced.
- All outputs are registered. tx_done is registered but combinationally cleared the next cycle, so it is a single-cycle pulse.
- Handshake:
  - Transfer occurs on a clk_3125 edge where tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE.
  - tx_data is latched into the shift register on the transfer edge. Later changes on tx_data have no effect.
  - tx_valid=1 outside IDLE is ignored; the producer holds it.
- States:
  - IDLE: tx=1. On transfer go to SYNC; tx_ready falls and tx_busy rises in the following cycle.
  - SYNC: wait for baud_tick. On a tick, drive tx=0 and go to START. This aligns every bit to a full tick period; SYNC lasts 1..27 clocks.
  - START: on baud_tick, tx=shift[0], shift right, bit counter=0, go to DATA.
  - DATA: on each baud_tick, if counter==DATA_BITS-1 go to STOP (tx=1, stop counter=0). Otherwise increment the counter, tx=next shifted bit.
  - STOP: on baud_tick, if stop counter==STOP_BITS-1 go to IDLE, pulse tx_done, tx_ready=1, tx_busy=0. Otherwise increment the stop counter (tx stays 1).
- Bit period: every bit holds tx constant between consecutive baud_tick edges, exactly 27 clocks at default rates.
- Frame length from the first tick after SYNC to the return to IDLE is (1+DATA_BITS+STOP_BITS) ticks: 10 ticks = 270 clocks for 8N1.
- baud_tick arriving on the transfer cycle itself is not used; SYNC waits for the next tick.
- Back-to-back with tx_valid held high: the next byte is accepted in the cycle tx_done is high. The line then stays 1 until the next tick, so the inter-frame gap is one extra mark period minimum.
- Counters are sized $clog2(DATA_BITS) and 1 bit. No wrap beyond the terminal count is permitted.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit is computed as XOR of the latched data at transfer time.
  - A PARITY state between DATA and STOP drives the parity bit for one tick period.
  - Frame = 1+DATA_BITS+1+STOP_BITS ticks (11 for 8E1).
- Undefined: no parity state or logic; DATA goes directly to STOP.

Test Plan:
- Reset: hold reset=0 for 5 clocks with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0; no transfer occurs.
- 0x55 with 27-clock ticks -> tx sequence per tick: 0,1,0,1,0,1,0,1,0,1; each level lasts 27 clocks; tx_done pulses once, 270 clocks after the first post-SYNC tick; tx_ready then returns to 1.
- 0xA3, tx_data changed to 0xFF the cycle after transfer -> data bits on the line are 1,1,0,0,0,1,0,1 (0xA3 LSB-first); 0xFF never appears.
- tx_valid held high with 0x00 then 0xFF -> two full frames; second start bit begins ≥27 clocks after the first frame's tx_done; tx_valid ignored while tx_busy=1.
- Reset asserted during DATA bit 4 of 0x0F -> tx=1 within the same cycle; no tx_done; a fresh 0x0F after reset release transmits intact.
- With UART_TX_PARITY_EN, 0x07 -> parity bit 1 after bit 7, frame 11 ticks; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, LSB-first frame out on tx, bit timing from baud_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_3125,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [CW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic                 r_stop_cnt, w_stop_cnt_next;
  logic                 r_tx, w_tx_next;
  logic                 r_ready, w_ready_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_tx_next       = r_tx;
    w_ready_next    = r_ready;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_next   = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (tx_valid && r_ready) begin
          w_state_next = S_SYNC;
          w_shift_next = tx_data;
          w_ready_next = 1'b0;
          w_busy_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^tx_data;
`endif
        end
      end
      // Waiting for a fresh tick keeps the start bit a full bit period long.
      S_SYNC: begin
        if (baud_tick) begin
          w_tx_next    = 1'b0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_tx_next      = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = '0;
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = S_PARITY;
`else
            w_tx_next       = 1'b1;
            w_stop_cnt_next = 1'b0;
            w_state_next    = S_STOP;
`endif
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_tx_next      = r_shift[0];
            w_shift_next   = r_shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          w_tx_next       = 1'b1;
          w_stop_cnt_next = 1'b0;
          w_state_next    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
            w_ready_next = 1'b1;
            w_busy_next  = 1'b0;
          end else begin
            w_stop_cnt_next = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
        w_ready_next = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_3125 or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
      r_ready    <= w_ready_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, corner sequences and random bytes vs a frame model.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk_3125;
  logic       reset;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int  n_cmp;
  int  n_err;
  int  cyc;
  int  tick_div;
  int  last_done_cyc;
  bit  last_tick;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk_3125 (clk_3125),
    .reset    (reset),
    .baud_tick(baud_tick),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial begin
    clk_3125 = 1'b0;
    forever #160 clk_3125 = ~clk_3125;
  end

  // One-cycle tick every 27 clocks; last_tick records what the DUT saw at the latest edge.
  initial begin
    baud_tick = 1'b0;
    tick_div  = 0;
    cyc       = 0;
    last_tick = 1'b0;
    forever begin
      @(posedge clk_3125);
      last_tick = baud_tick;
      cyc++;
      #2;
      tick_div  = (tick_div == 26) ? 0 : tick_div + 1;
      baud_tick = (tick_div == 26);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start 0, data LSB-first, optional even parity, stop 1.
  function automatic string frame_str(input logic [7:0] d);
    string s;
    s = "0";
    for (int i = 0; i < 8; i++) s = {s, ((d >> i) & 8'd1) != 0 ? "1" : "0"};
`ifdef UART_TX_PARITY_EN
    s = {s, (^d) ? "1" : "0"};
`endif
    s = {s, "1"};
    return s;
  endfunction

  task automatic run_frame(input logic [7:0] data, input logic [7:0] alt, input bit change,
                           input bit hold, input bit b2b, input string line);
    int    k, nb, wait_c, t1, early_done, hs_bad;
    bit    bad, done_seen;
    logic  bad_val, exp_bit;
    string nm;
    nb = line.len();
    tx_data  = data;
    tx_valid = 1'b1;
    wait_c = 0;
    while (!tx_ready && wait_c < 1000) begin
      @(negedge clk_3125);
      wait_c++;
    end
    chk("ready_before_send", {31'd0, tx_ready}, 32'd1);
    @(posedge clk_3125);
    @(negedge clk_3125);
    if (!hold) tx_valid = 1'b0;
    if (change) tx_data = alt;
    chk("busy_after_xfer", {31'd0, tx_busy}, 32'd1);
    chk("ready_after_xfer", {31'd0, tx_ready}, 32'd0);
    k = 0; bad = 0; bad_val = 1'b0; early_done = 0; hs_bad = 0; t1 = 0; done_seen = 0;
    for (int c = 0; c < (nb + 2) * 27 + 10; c++) begin
      if (c > 0 && last_tick) begin
        exp_bit = (k == 0) ? 1'b1 : (line[k-1] == 8'h31);
        if (k == 0) nm = "sync_mark";
        else nm = $sformatf("data%02h_bit%0d", data, k - 1);
        chk(nm, {31'd0, bad ? bad_val : exp_bit}, {31'd0, exp_bit});
        if (k == 0) begin
          t1 = cyc;
          if (b2b) chk("b2b_gap_ge27", {31'd0, (cyc - last_done_cyc) >= 27}, 32'd1);
        end
        k++;
        bad = 0;
        if (k == nb + 1) begin
          chk("done_pulse", {31'd0, tx_done}, 32'd1);
          chk("ready_at_done", {31'd0, tx_ready}, 32'd1);
          chk("busy_at_done", {31'd0, tx_busy}, 32'd0);
          chk("tx_mark_at_done", {31'd0, tx}, 32'd1);
          chk("frame_clocks", cyc - t1, nb * 27);
          last_done_cyc = cyc;
          done_seen = 1;
          break;
        end
      end
      exp_bit = (k == 0) ? 1'b1 : (line[k-1] == 8'h31);
      if (tx !== exp_bit && !bad) begin
        bad = 1;
        bad_val = tx;
      end
      if (tx_done) early_done++;
      if (tx_busy !== 1'b1 || tx_ready !== 1'b0) hs_bad++;
      @(negedge clk_3125);
    end
    chk("frame_completed", {31'd0, done_seen}, 32'd1);
    chk("early_done", early_done, 0);
    chk("busy_ready_hold", hs_bad, 0);
    $display("frame data=%02h line=%s ticks=%0d", data, line, k);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] alt;
    bit         change;
    bit         hold;
    bit         b2b;
    string      line;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int k, gap, tmo, dcnt;
    logic [7:0] d;
    n_cmp = 0;
    n_err = 0;
    last_done_cyc = 0;
`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'h07, 8'h00, 1'b0, 1'b0, 1'b0, "01110000011"};
    tbl[1] = '{8'h03, 8'h00, 1'b0, 1'b0, 1'b0, "01100000001"};
    tbl[2] = '{8'hA3, 8'hFF, 1'b1, 1'b0, 1'b0, "01100010101"};
    tbl[3] = '{8'h55, 8'h00, 1'b0, 1'b1, 1'b0, "01010101001"};
    tbl[4] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, "01111111101"};
`else
    tbl[0] = '{8'h55, 8'h00, 1'b0, 1'b0, 1'b0, "0101010101"};
    tbl[1] = '{8'hA3, 8'hFF, 1'b1, 1'b0, 1'b0, "0110001011"};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "0000000001"};
    tbl[3] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, "0111111111"};
    tbl[4] = '{8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, "0111100001"};
`endif

    // Reset held with a pending byte: nothing may be accepted.
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    repeat (5) @(negedge clk_3125);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    tx_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk_3125);
    chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].data, tbl[i].alt, tbl[i].change, tbl[i].hold, tbl[i].b2b, tbl[i].line);
    @(negedge clk_3125);
    chk("idle_after_table", {31'd0, tx_busy}, 32'd0);

    // Reset in the middle of data bit 4 of 0x0F.
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(posedge clk_3125);
    @(negedge clk_3125);
    tx_valid = 1'b0;
    k = 0;
    tmo = 0;
    while (k < 6 && tmo < 400) begin
      @(negedge clk_3125);
      if (last_tick) k++;
      tmo++;
    end
    chk("reach_bit4", k, 6);
    repeat (3) @(negedge clk_3125);
    chk("bit4_level", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_ready", {31'd0, tx_ready}, 32'd1);
    chk("abort_busy", {31'd0, tx_busy}, 32'd0);
    dcnt = 0;
    repeat (4) begin
      @(negedge clk_3125);
      if (tx_done) dcnt++;
    end
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk_3125);
      if (tx_done || !tx) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_frame(8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, frame_str(8'h0F));

    // Random bytes, idle gaps and post-transfer data changes.
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 40);
      repeat (gap) @(negedge clk_3125);
      chk("idle_mark", {31'd0, tx}, 32'd1);
      run_frame(d, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, frame_str(d));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
